// File: rtl/multi_channel_scoreboard_if.sv
// rtl/multi_channel_scoreboard_if.sv - observation bus between an arbitrated multi-channel FIFO and its scoreboard
interface multi_channel_scoreboard_if #(
    parameter int NCH   = 4,
    parameter int WIDTH = 8,
    parameter int CHW   = $clog2(NCH)
);
    logic [NCH-1:0]       push;
    logic [NCH-1:0]       pop;
    logic [NCH*WIDTH-1:0] data_in;
    logic [WIDTH-1:0]     data_out;
    logic                 start;
    logic [CHW-1:0]       start_ch;
    logic                 en;
    logic [CHW-1:0]       captured_ch;
    logic                 data_out_vld;
    logic                 done;
    logic                 prop_signal;
    logic [2:0]           err;

    modport master (
        output push, pop, data_in, data_out, start, start_ch,
        input  en, captured_ch, data_out_vld, done, prop_signal, err
    );

    modport slave (
        input  push, pop, data_in, data_out, start, start_ch,
        output en, captured_ch, data_out_vld, done, prop_signal, err
    );
endinterface

// File: rtl/multi_channel_scoreboard.sv
// rtl/multi_channel_scoreboard.sv - magic-packet tracker with per-channel occupancy and protocol error flags
module multi_channel_scoreboard #(
    parameter int NCH    = 4,
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 8,
    parameter int CHW    = $clog2(NCH),
    parameter int CNTWID = $clog2(DEPTH) + 1
) (
    input logic                      clk,
    input logic                      rst,
    multi_channel_scoreboard_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_DONE} state_t;

    state_t            r_state;
    logic [CNTWID-1:0] r_occ [NCH];
    logic [CNTWID-1:0] r_cnt;
    logic [WIDTH-1:0]  r_magic;
    logic [CHW-1:0]    r_cap_ch;
    logic [2:0]        r_err;

    logic [NCH-1:0]    w_unf;
    logic [NCH-1:0]    w_ovf;
    logic [NCH-1:0]    w_pop_eff;
    logic [NCH-1:0]    w_push_eff;
    logic [CNTWID-1:0] w_occ_next [NCH];
    logic              w_multi;
    logic              w_ch_ok;
    logic              w_capture;
    logic              w_cap_pop;
    logic              w_vld;
    logic [CNTWID-1:0] w_cap_cnt;

    // A rejected pop/push leaves the counter alone but the other strobe still counts.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_unf[i]      = bus.pop[i] && (r_occ[i] == '0);
            w_ovf[i]      = bus.push[i] && !bus.pop[i] && (r_occ[i] == CNTWID'(DEPTH));
            w_pop_eff[i]  = bus.pop[i] && !w_unf[i];
            w_push_eff[i] = bus.push[i] && !w_ovf[i];
            w_occ_next[i] = r_occ[i] + {{(CNTWID-1){1'b0}}, w_push_eff[i]}
                                     - {{(CNTWID-1){1'b0}}, w_pop_eff[i]};
        end
    end

    assign w_multi   = (bus.pop & (bus.pop - NCH'(1))) != '0;
    assign w_ch_ok   = (32'(bus.start_ch) < NCH);
    assign w_capture = (r_state == S_IDLE) && bus.start && w_ch_ok && bus.push[bus.start_ch];
    // Entries at or ahead of the magic packet; a same-cycle pop leaves from the head first.
    assign w_cap_cnt = r_occ[bus.start_ch] + CNTWID'(1)
                       - {{(CNTWID-1){1'b0}}, w_pop_eff[bus.start_ch]};
    assign w_cap_pop = bus.pop[r_cap_ch];
    assign w_vld     = (r_state == S_TRACK) && w_cap_pop && (r_cnt == CNTWID'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_magic  <= '0;
            r_cap_ch <= '0;
            r_err    <= '0;
            for (int i = 0; i < NCH; i++) r_occ[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) r_occ[i] <= w_occ_next[i];
            r_err <= r_err | {w_multi, |w_unf, |w_ovf};
            case (r_state)
                S_IDLE: begin
                    if (w_capture) begin
                        r_state  <= S_TRACK;
                        r_magic  <= bus.data_in[bus.start_ch*WIDTH +: WIDTH];
                        r_cap_ch <= bus.start_ch;
                        r_cnt    <= w_cap_cnt;
                    end
                end
                S_TRACK: begin
                    if (w_vld) begin
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                    end else if (w_cap_pop && (r_cnt != '0)) begin
                        r_cnt <= r_cnt - CNTWID'(1);
                    end
                end
                S_DONE:  r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.en           = (r_state != S_IDLE);
    assign bus.done         = (r_state == S_DONE);
    assign bus.captured_ch  = r_cap_ch;
    assign bus.data_out_vld = w_vld;
    assign bus.prop_signal  = !w_vld || (r_magic == bus.data_out);
    assign bus.err          = r_err;
endmodule

// File: tb/tb_multi_channel_scoreboard.sv
// tb/tb_multi_channel_scoreboard.sv - queue-model scoreboard bench for multi_channel_scoreboard
module tb_multi_channel_scoreboard;
    localparam int NCH = 4;
    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic       en;
        logic       done;
        logic       vld;
        logic       prop;
        logic [1:0] cap;
        logic [2:0] err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multi_channel_scoreboard_if #(.NCH(NCH), .WIDTH(WIDTH)) bus ();
    multi_channel_scoreboard #(.NCH(NCH), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    // Reference: real FIFO contents per channel, magic packet marked by a flag bit.
    logic [7:0] md [NCH][DEPTH+1];
    bit         mm [NCH][DEPTH+1];
    int         mn [NCH];
    bit         m_cap, m_exit;
    logic [7:0] m_magic;
    int         m_ch;
    logic [2:0] m_err;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("en", 32'(bus.en), 32'(e.en));
            check("done", 32'(bus.done), 32'(e.done));
            check("data_out_vld", 32'(bus.data_out_vld), 32'(e.vld));
            check("prop_signal", 32'(bus.prop_signal), 32'(e.prop));
            check("captured_ch", 32'(bus.captured_ch), 32'(e.cap));
            check("err", 32'(bus.err), 32'(e.err));
        end
    end

    function automatic logic [31:0] dch(input int c, input logic [7:0] v);
        return 32'(v) << (8 * c);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) mn[c] = 0;
        m_cap = 0; m_exit = 0; m_magic = '0; m_ch = 0; m_err = '0;
    endtask

    task automatic zero_inputs();
        bus.push = '0; bus.pop = '0; bus.data_in = '0; bus.data_out = '0;
        bus.start = 1'b0; bus.start_ch = '0;
    endtask

    // Reset lands between clock edges, so the outputs must drop without an edge.
    task automatic do_reset();
        @(posedge clk);
        #1;
        zero_inputs();
        rst = 1'b0;
        #1;
        check("rst_en", 32'(bus.en), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_vld", 32'(bus.data_out_vld), 0);
        check("rst_prop", 32'(bus.prop_signal), 1);
        check("rst_err", 32'(bus.err), 0);
        check("rst_cap", 32'(bus.captured_ch), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic cyc(input logic [3:0] ps, input logic [3:0] pp, input logic [31:0] din,
                       input logic st, input logic [1:0] stch, input logic [7:0] xr);
        exp_t e;
        logic [7:0] dout;
        bit vld, cap_now;
        int first;
        @(posedge clk);
        #1;
        first = -1;
        for (int c = NCH - 1; c >= 0; c--) if (pp[c]) first = c;
        if (m_cap && !m_exit && pp[m_ch] && mn[m_ch] > 0) dout = md[m_ch][0] ^ xr;
        else if (first >= 0 && mn[first] > 0) dout = md[first][0] ^ xr;
        else dout = 8'(first + 1) ^ xr;
        bus.push = ps; bus.pop = pp; bus.data_in = din; bus.data_out = dout;
        bus.start = st; bus.start_ch = stch;

        vld = m_cap && !m_exit && pp[m_ch] && mn[m_ch] > 0 && mm[m_ch][0];
        e.en = m_cap; e.done = m_exit; e.vld = vld;
        e.prop = !vld || (dout == m_magic);
        e.cap = 2'(m_ch); e.err = m_err;
        sb.push_back(e);

        cap_now = !m_cap && st && ps[stch];
        if ($countones(pp) > 1) m_err[2] = 1'b1;
        if (vld) m_exit = 1;
        for (int c = 0; c < NCH; c++) begin
            if (pp[c]) begin
                if (mn[c] == 0) m_err[1] = 1'b1;
                else begin
                    for (int j = 0; j < mn[c] - 1; j++) begin
                        md[c][j] = md[c][j+1];
                        mm[c][j] = mm[c][j+1];
                    end
                    mn[c]--;
                end
            end
            if (ps[c]) begin
                if (mn[c] == DEPTH) m_err[0] = 1'b1;
                else begin
                    md[c][mn[c]] = din[8*c +: 8];
                    mm[c][mn[c]] = cap_now && (c == int'(stch));
                    mn[c]++;
                end
            end
        end
        if (cap_now) begin
            m_cap = 1; m_ch = int'(stch); m_magic = din[8*stch +: 8];
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(4'b0, 4'b0, 32'h0, 1'b0, 2'd0, 8'h0);
    endtask

    initial begin
        rst = 1'b1;
        zero_inputs();
        model_reset();
        do_reset();

        cyc(4'b0100, 4'b0, dch(2, 8'hA5), 1'b1, 2'd2, 8'h0);
        cyc(4'b0, 4'b0100, 32'h0, 1'b0, 2'd0, 8'h0);
        idle(2);

        do_reset();
        for (int i = 0; i < 3; i++) cyc(4'b0010, 4'b0, dch(1, 8'(8'h10 + i)), 1'b0, 2'd0, 8'h0);
        for (int i = 0; i < 2; i++) cyc(4'b0001, 4'b0, dch(0, 8'(8'h20 + i)), 1'b0, 2'd0, 8'h0);
        cyc(4'b0010, 4'b0, dch(1, 8'h3C), 1'b1, 2'd1, 8'h0);
        cyc(4'b0011, 4'b0001, dch(0, 8'h21) | dch(1, 8'h40), 1'b0, 2'd0, 8'h0);
        cyc(4'b0, 4'b0010, 32'h0, 1'b0, 2'd0, 8'h0);
        cyc(4'b0001, 4'b0, dch(0, 8'h22), 1'b0, 2'd0, 8'h0);
        cyc(4'b0, 4'b0010, 32'h0, 1'b0, 2'd0, 8'h0);
        cyc(4'b0010, 4'b0001, dch(1, 8'h41), 1'b0, 2'd0, 8'h0);
        cyc(4'b0, 4'b0010, 32'h0, 1'b0, 2'd0, 8'h0);
        cyc(4'b0, 4'b0010, 32'h0, 1'b0, 2'd0, 8'h0);
        cyc(4'b0, 4'b0010, 32'h0, 1'b0, 2'd0, 8'h0);
        idle(1);

        do_reset();
        for (int i = 0; i < 2; i++) cyc(4'b1000, 4'b0, dch(3, 8'(8'h50 + i)), 1'b0, 2'd0, 8'h0);
        cyc(4'b1000, 4'b1000, dch(3, 8'h77), 1'b1, 2'd3, 8'h0);
        cyc(4'b0, 4'b1000, 32'h0, 1'b0, 2'd0, 8'h0);
        cyc(4'b0, 4'b1000, 32'h0, 1'b0, 2'd0, 8'h0);
        idle(1);

        do_reset();
        cyc(4'b0001, 4'b0, dch(0, 8'h11), 1'b1, 2'd0, 8'h0);
        cyc(4'b0, 4'b0001, 32'h0, 1'b0, 2'd0, 8'h03);
        idle(1);

        do_reset();
        cyc(4'b0, 4'b0001, 32'h0, 1'b0, 2'd0, 8'h0);
        idle(1);
        for (int i = 0; i < 9; i++) cyc(4'b0010, 4'b0, dch(1, 8'(i)), 1'b0, 2'd0, 8'h0);
        cyc(4'b0001, 4'b0, dch(0, 8'h99), 1'b0, 2'd0, 8'h0);
        cyc(4'b0, 4'b0011, 32'h0, 1'b0, 2'd0, 8'h0);
        idle(2);

        do_reset();
        cyc(4'b0100, 4'b0, dch(2, 8'h66), 1'b0, 2'd0, 8'h0);
        cyc(4'b0100, 4'b0, dch(2, 8'h67), 1'b1, 2'd2, 8'h0);
        idle(1);
        do_reset();
        cyc(4'b0001, 4'b0, dch(0, 8'hC3), 1'b1, 2'd0, 8'h0);
        cyc(4'b0, 4'b0001, 32'h0, 1'b0, 2'd0, 8'h0);
        idle(1);

        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int k = 0; k < 120; k++) begin
                logic [3:0] ps, pp;
                logic [1:0] stch;
                logic       st;
                logic [7:0] xr;
                ps = 4'($urandom);
                for (int c = 0; c < NCH; c++) if (mn[c] >= DEPTH && ($urandom % 4 != 0)) ps[c] = 1'b0;
                pp = 4'b0;
                if ($urandom % 2 == 0) begin
                    int c;
                    c = $urandom_range(0, NCH - 1);
                    if (mn[c] > 0 || ($urandom % 8 == 0)) pp[c] = 1'b1;
                end
                if ($urandom % 25 == 0) pp = 4'($urandom);
                stch = 2'($urandom);
                st = !m_cap && ($urandom % 6 == 0) && mn[stch] < DEPTH;
                if (st) ps[stch] = 1'b1;
                xr = ($urandom % 6 == 0) ? 8'($urandom_range(1, 255)) : 8'h0;
                cyc(ps, pp, $urandom, st, stch, xr);
            end
            idle(1);
        end

        @(posedge clk);
        @(posedge clk);
        check("sb_drain", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multi_channel_scoreboard.md
Name: multi_channel_scoreboard

Overview:
- Formal/simulation scoreboard for an NCH-channel arbitrated FIFO (NCH input FIFOs, one shared arbitrated output).
- Tracks one "magic packet" pushed into a chosen channel and follows it through that channel's FIFO.
- Flags when it leaves on the shared output, and checks that the exiting data equals the captured value.
- Also keeps per-channel occupancy and reports protocol errors (overflow, underflow, non-exclusive pops).

Parameters:
- NCH, 4, number of FIFO channels (>=2).
- DEPTH, 8, depth of each channel FIFO.
- WIDTH, 8, data width.
- CHW, $clog2(NCH), channel index width.
- CNTWID, $clog2(DEPTH)+1, occupancy/tracking counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- push  input  NCH  per-channel push strobe into each FIFO.
- pop  input  NCH  per-channel pop strobe issued by the arbiter.
- data_in  input  NCH*WIDTH  packed per-channel input data; channel i at [i*WIDTH +: WIDTH].
- data_out  input  WIDTH  shared arbitrated output data, valid in the cycle of the pop.
- start  input  1  request to capture the magic packet.
- start_ch  input  CHW  channel from which the magic packet is taken.
- en  output  1  magic packet captured (state != IDLE).
- captured_ch  output  CHW  channel holding the magic packet.
- data_out_vld  output  1  magic packet is on data_out this cycle.
- done  output  1  magic packet has exited (state == DONE).
- prop_signal  output  1  ~data_out_vld | (magic == data_out).
- err  output  3  sticky flags: [0] overflow, [1] underflow, [2] multi-pop.

Behaviour:
- Reset (rst low, asynchronous; mid-operation included): state=IDLE; all occ[i]=0; cnt=0; magic=0; captured_ch=0; err=0.
  - Outputs during and after reset: en=0, done=0, data_out_vld=0, prop_signal=1.
- Occupancy: for each channel i, occ_next[i] = occ[i] + push[i] - pop[i], computed in CNTWID bits.
  - pop[i] with occ[i]==0: set err[1]; occ[i] holds (a push in the same cycle still increments it).
  - push[i] with occ[i]==DEPTH and ~pop[i]: set err[0]; occ[i] holds.
  - More than one bit of pop set in a cycle: set err[2]; counters still update per channel.
  - err bits clear only on reset.
- FSM states: IDLE, TRACK, DONE.
- IDLE -> TRACK when start & push[start_ch]. At that edge:
  - magic <= data_in[start_ch].
  - captured_ch <= start_ch.
  - cnt <= occ[start_ch] + 1 - pop[start_ch] (count of entries at or ahead of the magic packet, including it).
  - start without push[start_ch]: no capture, remain IDLE.
  - start_ch >= NCH: no capture.
- TRACK:
  - Only pop[captured_ch] affects cnt: cnt <= cnt - pop[captured_ch]. Pushes never affect cnt (they queue behind the magic packet).
  - data_out_vld = pop[captured_ch] & (cnt == 1), combinational in the same cycle.
  - On data_out_vld: TRACK -> DONE at the next edge; cnt -> 0.
  - Capture and exit never occur in the same cycle, because the FIFO has no pass-through. Minimum latency is 1 cycle after capture.
  - start is ignored; only one magic packet is captured per reset.
- DONE: terminal until reset. data_out_vld=0; prop_signal=1; occupancy and err tracking continue.
- pop[captured_ch] in TRACK with cnt==0 cannot occur while occ is consistent; if it does, cnt holds at 0 and err[1] is set via the occupancy check.
- en = (state != IDLE); done = (state == DONE). Both are registered-state derived, so no glitch on data_out_vld from other channels' pops.
- prop_signal is purely combinational from data_out_vld, magic and data_out.

Test Plan:
- Reset, then start=1, start_ch=2, push=4'b0100, data_in ch2=8'hA5 with occ[2]=0 -> next cycle en=1, captured_ch=2, cnt=1. Pop ch2 with data_out=8'hA5 -> data_out_vld=1, prop_signal=1; next cycle done=1.
- Push 3 items into ch1, then capture in ch1 (magic=8'h3C); interleave pushes on ch0/ch1 and pops on ch0 -> data_out_vld asserts exactly on the 4th pop of ch1 and on no other pop.
- Capture in ch3 with occ[3]=2 and pop[3] in the same cycle -> cnt=2; exits on the 2nd subsequent ch3 pop.
- Corrupt data: magic=8'h11 exits with data_out=8'h12 -> data_out_vld=1, prop_signal=0 for that cycle only.
- Error flags: pop ch0 while empty -> err=3'b010; push ch1 nine times with DEPTH=8 -> err[0]=1; pop=4'b0011 -> err[2]=1; all remain set until rst low.
- Assert rst low mid-TRACK (asynchronously, between edges) -> en, done, err, occupancy immediately 0. A fresh start/push after release captures normally.
